// File: rtl/bytes2bits_stream_ctrl_if.sv
// Byte-in / word-out stream bundle for bytes2bits_stream_ctrl.
// The controller connects as slave; the byte source and word sink connect as master.
interface bytes2bits_stream_ctrl_if #(
    parameter int N_BYTES = 4
);
    localparam int IDX_W = $clog2(N_BYTES + 1);

    logic [7:0]             byte_i;
    logic                   byte_valid_i;
    logic                   byte_ready_o;
    logic [N_BYTES*8-1:0]   bits_o;
    logic [IDX_W-1:0]       bits_nbytes_o;
    logic                   bits_last_o;
    logic                   bits_valid_o;
    logic                   bits_ready_i;

    modport master (
        output byte_i, byte_valid_i, bits_ready_i,
        input  byte_ready_o, bits_o, bits_nbytes_o, bits_last_o, bits_valid_o
    );

    modport slave (
        input  byte_i, byte_valid_i, bits_ready_i,
        output byte_ready_o, bits_o, bits_nbytes_o, bits_last_o, bits_valid_o
    );
endinterface

// File: rtl/bytes2bits_stream_ctrl.sv
// Groups a length-delimited byte stream into N_BYTES-wide words, zero-padding
// the final partial word, and emits them over a valid/ready handshake.
module bytes2bits #(
    parameter int N_BYTES = 4
) (
    input  logic [N_BYTES-1:0][7:0] bytes_i,
    output logic [N_BYTES*8-1:0]    bits_o
);
    // Byte j, bit k maps to output bit j*8+k: first byte ends up LSB-first.
    always_comb begin
        bits_o = '0;
        for (int j = 0; j < N_BYTES; j++) begin
            for (int k = 0; k < 8; k++) begin
                bits_o[j*8+k] = bytes_i[j][k];
            end
        end
    end
endmodule

module bytes2bits_stream_ctrl #(
    parameter int N_BYTES = 4,
    parameter int LEN_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [LEN_W-1:0]         len_i,
    output logic                     busy_o,
    output logic                     done_o,
    bytes2bits_stream_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(N_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        remaining_q;
    logic [IDX_W-1:0]        idx_q;
    logic [N_BYTES-1:0][7:0] buf_q;
    logic [IDX_W-1:0]        nbytes_q;
    logic                    last_q;

    logic byte_ready;
    logic bits_valid;
    logic byte_fire;
    logic bits_fire;
    logic group_done;

    assign byte_fire  = bus.byte_valid_i && byte_ready;
    assign bits_fire  = bits_valid && bus.bits_ready_i;
    // A group closes on its last slot or on the last byte of the message.
    assign group_done = byte_fire &&
                        ((idx_q == IDX_W'(N_BYTES - 1)) || (remaining_q == LEN_W'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        bits_valid = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                byte_ready = 1'b1;
                if (group_done) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                bits_valid = 1'b1;
                if (bits_fire) begin
                    state_d = last_q ? DONE : FILL;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            remaining_q <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            nbytes_q    <= '0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && (len_i != '0)) begin
                        remaining_q <= len_i;
                        idx_q       <= '0;
                        buf_q       <= '0;
                    end
                end
                FILL: begin
                    if (byte_fire) begin
                        for (int j = 0; j < N_BYTES; j++) begin
                            if (idx_q == IDX_W'(j)) begin
                                buf_q[j] <= bus.byte_i;
                            end
                        end
                        idx_q       <= idx_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                    end
                    if (group_done) begin
                        nbytes_q <= idx_q + 1'b1;
                        last_q   <= (remaining_q == LEN_W'(1));
                    end
                end
                OUT: begin
                    // Clearing here keeps the unfilled slots of the next word at zero.
                    if (bits_fire && !last_q) begin
                        idx_q <= '0;
                        buf_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    bytes2bits #(.N_BYTES(N_BYTES)) u_b2b (
        .bytes_i (buf_q),
        .bits_o  (bus.bits_o)
    );

    assign busy_o            = (state_q != IDLE);
    assign bus.byte_ready_o  = byte_ready;
    assign bus.bits_valid_o  = bits_valid;
    assign bus.bits_nbytes_o = nbytes_q;
    assign bus.bits_last_o   = last_q;
endmodule

// File: tb/tb_bytes2bits_stream_ctrl.sv
// Directed bench for bytes2bits_stream_ctrl: a table of messages with hand-computed
// output words, plus hand-written zero-length and mid-message reset sequences.
module tb_bytes2bits_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    bytes2bits_stream_ctrl_if #(.N_BYTES(4)) bus ();

    bytes2bits_stream_ctrl #(.N_BYTES(4), .LEN_W(16)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .len_i   (len),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              len;
        logic [7:0][7:0] data;      // data[0] is the first byte sent
        int              nwords;
        logic [2:0][31:0] exp_word;
        logic [2:0][3:0] exp_nb;
        logic [2:0]      exp_last;
        bit              stall;     // hold bits_ready low 3 cycles on first word
        bit              gaps;      // drop byte_valid every third cycle
        bit              restart;   // assert start mid-message (must be ignored)
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_msg(input vec_t v, input string tag);
        int  bi = 0;
        int  wi = 0;
        int  cyc = 0;
        int  last_hs = -10;
        int  stall_left;
        bit  done_seen = 0;
        bit  restarted = 0;
        stall_left = v.stall ? 3 : 0;
        @(negedge clk);
        start = 1'b1;
        len   = 16'(v.len);
        @(negedge clk);
        start = 1'b0;
        len   = 16'hFFFF;
        while (!done_seen && cyc < 300) begin
            start = 1'b0;
            if (v.restart && !restarted && bi == 2) begin
                start     = 1'b1;
                len       = 16'd2;
                restarted = 1;
            end
            bus.byte_valid_i = (bi < v.len) && !(v.gaps && (cyc % 3 == 1));
            bus.byte_i       = (bi < v.len) ? v.data[bi] : 8'h00;
            #1;
            bus.bits_ready_i = !(bus.bits_valid_o && stall_left > 0);
            #1;
            if (done) begin
                done_seen = 1;
                chk({tag, " done_after_hs"}, 64'(cyc - last_hs), 64'd1);
                chk({tag, " word_count"}, 64'(wi), 64'(v.nwords));
                chk({tag, " busy_at_done"}, 64'(busy), 64'd1);
            end
            if (bus.bits_valid_o) begin
                if (wi >= v.nwords) begin
                    chk({tag, " extra_word"}, 64'(wi), 64'(v.nwords - 1));
                end else begin
                    chk({tag, " bits"}, 64'(bus.bits_o), 64'(v.exp_word[wi]));
                    chk({tag, " nbytes"}, 64'(bus.bits_nbytes_o), 64'(v.exp_nb[wi]));
                    chk({tag, " last"}, 64'(bus.bits_last_o), 64'(v.exp_last[wi]));
                    if (!bus.bits_ready_i) begin
                        chk({tag, " byte_ready_in_stall"}, 64'(bus.byte_ready_o), 64'd0);
                        stall_left--;
                    end else begin
                        wi++;
                        last_hs = cyc;
                    end
                end
            end
            if (bus.byte_valid_i && bus.byte_ready_o) bi++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.bits_ready_i = 1'b1;
        chk({tag, " done_seen"}, 64'(done_seen), 64'd1);
        if (!done_seen) begin
            $display("FAIL %s timeout actual=%0d cycles required=done", tag, cyc);
        end
        #1;
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Concatenations list the last byte/word first so index 0 is the first one.
        vecs[0] = '{len: 8, data: {8'h67, 8'h45, 8'h23, 8'h01, 8'h89, 8'hAB, 8'hCD, 8'hEF},
                    nwords: 2, exp_word: {32'h0, 32'h67452301, 32'h89ABCDEF},
                    exp_nb: {4'd0, 4'd4, 4'd4}, exp_last: 3'b010,
                    stall: 0, gaps: 0, restart: 0};
        vecs[1] = '{len: 5, data: {8'h0, 8'h0, 8'h0, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00},
                    nwords: 2, exp_word: {32'h0, 32'h00000044, 32'h33221100},
                    exp_nb: {4'd0, 4'd1, 4'd4}, exp_last: 3'b010,
                    stall: 0, gaps: 0, restart: 0};
        vecs[2] = '{len: 6, data: {8'h0, 8'h0, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10},
                    nwords: 2, exp_word: {32'h0, 32'h00006050, 32'h40302010},
                    exp_nb: {4'd0, 4'd2, 4'd4}, exp_last: 3'b010,
                    stall: 1, gaps: 1, restart: 0};
        vecs[3] = '{len: 3, data: {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h03, 8'h02, 8'h01},
                    nwords: 1, exp_word: {32'h0, 32'h0, 32'h00030201},
                    exp_nb: {4'd0, 4'd0, 4'd3}, exp_last: 3'b001,
                    stall: 0, gaps: 0, restart: 0};
        vecs[4] = '{len: 8, data: {8'h67, 8'h45, 8'h23, 8'h01, 8'h89, 8'hAB, 8'hCD, 8'hEF},
                    nwords: 2, exp_word: {32'h0, 32'h67452301, 32'h89ABCDEF},
                    exp_nb: {4'd0, 4'd4, 4'd4}, exp_last: 3'b010,
                    stall: 0, gaps: 0, restart: 1};

        rst = 1'b1;
        start = 1'b0;
        len = '0;
        bus.byte_i = '0;
        bus.byte_valid_i = 1'b0;
        bus.bits_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset byte_ready", 64'(bus.byte_ready_o), 64'd0);
        chk("reset bits_valid", 64'(bus.bits_valid_o), 64'd0);
        chk("reset bits", 64'(bus.bits_o), 64'd0);
        chk("reset nbytes", 64'(bus.bits_nbytes_o), 64'd0);
        chk("reset last", 64'(bus.bits_last_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_msg(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero length: straight to DONE, no output word.
        @(negedge clk);
        start = 1'b1;
        len   = 16'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero done", 64'(done), 64'd1);
        chk("zero busy", 64'(busy), 64'd1);
        chk("zero bits_valid", 64'(bus.bits_valid_o), 64'd0);
        @(negedge clk);
        #1;
        chk("zero done_clear", 64'(done), 64'd0);
        chk("zero busy_clear", 64'(busy), 64'd0);

        // Reset after two of four bytes: discard everything, no done pulse.
        @(negedge clk);
        start = 1'b1;
        len   = 16'd4;
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid_i = 1'b1;
        bus.byte_i = 8'h11;
        @(negedge clk);
        bus.byte_i = 8'h22;
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort byte_ready", 64'(bus.byte_ready_o), 64'd0);
        chk("abort bits_valid", 64'(bus.bits_valid_o), 64'd0);
        chk("abort bits", 64'(bus.bits_o), 64'd0);
        chk("abort nbytes", 64'(bus.bits_nbytes_o), 64'd0);
        @(negedge clk);
        #1;
        chk("abort no_done", 64'(done), 64'd0);
        vecs[3].len      = 4;
        vecs[3].data     = {8'h0, 8'h0, 8'h0, 8'h0, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        vecs[3].exp_word = {32'h0, 32'h0, 32'hDDCCBBAA};
        vecs[3].exp_nb   = {4'd0, 4'd0, 4'd4};
        run_msg(vecs[3], "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
